// File: rtl/line_fetcher_if.sv
// Memory read bus between the line fetcher (master) and the framebuffer
// memory (slave). mem_data is valid in the same cycle that mem_ack is high.
interface line_fetcher_if;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/line_fetcher.sv
// line_fetcher: prefetches the next VGA scan line from the framebuffer into
// one bank of a double-banked 2048x8 line buffer while the VGA stage reads
// the other bank. A line change during an unfinished fetch aborts it, sets
// the sticky underrun flag and restarts on the new target line.
// Optional build macro LINE_FETCH_STATS_EN adds a saturating underrun_count.
module line_fetcher (
  input  logic          clk100,
  input  logic          rst,
  input  logic [9:0]    Line,
  input  logic [10:0]   PxAddr,
  output logic [7:0]    PxData,
  line_fetcher_if.master mem,
  input  logic          underrun_clr,
  output logic          underrun
`ifdef LINE_FETCH_STATS_EN
  ,
  output logic [15:0]   underrun_count
`endif
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam logic [9:0] LAST_COL = 10'd639;

  // Framebuffer byte address of the first pixel of line t (t*640 = t*512 + t*128).
  function automatic logic [18:0] line_base(input logic [9:0] t);
    logic [18:0] w;
    w = {9'd0, t};
    return (w << 9) + (w << 7);
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  line_q, line_d;
  logic [9:0]  column_q, column_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic        bank_q, bank_d;
  logic        pend_q, pend_d;
  logic [9:0]  pend_tgt_q, pend_tgt_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  px_data_q, px_data_d;

  logic [7:0]  line_buf [0:2047];

  logic        trigger_s;
  logic        has_tgt_s;
  logic [9:0]  tgt_s;
  logic        start_s;
  logic [9:0]  start_tgt_s;
  logic        wr_en_s;
  logic [10:0] wr_addr_s;
  logic        underrun_evt_s;

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] count_q, count_d;
`endif

  // Line-change detection and the line to fetch next (none during vblank).
  always_comb begin
    trigger_s = (Line != line_q);
    if (Line <= 10'd478) begin
      has_tgt_s = 1'b1;
      tgt_s     = Line + 10'd1;
    end else if (Line == 10'd524) begin
      has_tgt_s = 1'b1;
      tgt_s     = 10'd0;
    end else begin
      has_tgt_s = 1'b0;
      tgt_s     = 10'd0;
    end
  end

  // Fetch sequencing, handshake, buffer write enable and underrun flag.
  always_comb begin
    state_d        = state_q;
    line_d         = Line;
    column_d       = column_q;
    mem_addr_d     = mem_addr_q;
    mem_req_d      = mem_req_q;
    bank_d         = bank_q;
    pend_d         = 1'b0;
    pend_tgt_d     = pend_tgt_q;
    wr_en_s        = 1'b0;
    underrun_evt_s = 1'b0;
    start_s        = 1'b0;
    start_tgt_s    = tgt_s;
    px_data_d      = line_buf[PxAddr];

    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (trigger_s) begin
          start_s     = has_tgt_s;
          start_tgt_s = tgt_s;
        end else if (pend_q) begin
          // Restart deferred by one cycle after an aborted fetch.
          start_s     = 1'b1;
          start_tgt_s = pend_tgt_q;
        end else begin
          start_s = 1'b0;
        end
      end
      FETCH: begin
        if (trigger_s) begin
          // Abort: a coinciding ack is dropped, request goes low for one cycle.
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          underrun_evt_s = 1'b1;
          pend_d         = has_tgt_s;
          pend_tgt_d     = tgt_s;
        end else if (mem_req_q && mem.mem_ack) begin
          wr_en_s = 1'b1;
          if (column_q == LAST_COL) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            column_d   = column_q + 10'd1;
            mem_addr_d = mem_addr_q + 19'd1;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (start_s) begin
      state_d    = FETCH;
      mem_req_d  = 1'b1;
      column_d   = 10'd0;
      mem_addr_d = line_base(start_tgt_s);
      bank_d     = start_tgt_s[0];
    end else begin
      bank_d = bank_d;
    end

    if (underrun_evt_s) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  assign wr_addr_s = {bank_q, column_q};

`ifdef LINE_FETCH_STATS_EN
  // Saturating count of underrun events; only reset clears it.
  always_comb begin
    if (underrun_evt_s && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign underrun_count = count_q;
`endif

  // Control, address and output registers.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= 10'd0;
      column_q   <= 10'd0;
      mem_addr_q <= 19'd0;
      mem_req_q  <= 1'b0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 10'd0;
      underrun_q <= 1'b0;
      px_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      column_q   <= column_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      underrun_q <= underrun_d;
      px_data_q  <= px_data_d;
    end
  end

  // Line buffer write port; contents survive reset.
  always_ff @(posedge clk100) begin
    if (wr_en_s) begin
      line_buf[wr_addr_s] <= mem.mem_data;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign PxData       = px_data_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Scoreboard bench for line_fetcher: the stimulus process queues expected
// memory addresses and pixel values; negedge monitors act as the memory,
// pop the queues and compare when the DUT presents a request or a pixel.
module tb_line_fetcher;

  logic        clk100;
  logic        rst;
  logic [9:0]  Line;
  logic [10:0] PxAddr;
  logic [7:0]  PxData;
  logic        underrun_clr;
  logic        underrun;
`ifdef LINE_FETCH_STATS_EN
  logic [15:0] underrun_count;
`endif

  line_fetcher_if mem_bus ();

  line_fetcher dut (
    .clk100       (clk100),
    .rst          (rst),
    .Line         (Line),
    .PxAddr       (PxAddr),
    .PxData       (PxData),
    .mem          (mem_bus),
    .underrun_clr (underrun_clr),
    .underrun     (underrun)
`ifdef LINE_FETCH_STATS_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  int vectors = 0;
  int fails   = 0;

  logic [18:0] exp_addr [$];
  logic [7:0]  px_q [$];
  int          ack_budget = 0;   // -1 unlimited, 0 withhold, >0 acks left
  int          ack_delay  = 0;
  int          wait_cnt   = 0;
  bit          waiting    = 1'b0;
  logic [18:0] held_addr  = 19'd0;
  bit          px_req     = 1'b0;
  bit          px_stage   = 1'b0;

  function automatic logic [7:0] pix(input logic [18:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic push_fetch(input int base, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(19'(base + i));
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_addr.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_addr.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d transfers pending after %0d cycles, expected 0", nm, exp_addr.size(), budget);
      exp_addr.delete();
    end
  endtask

  task automatic rd(input logic [10:0] a, input logic [7:0] e);
    PxAddr = a;
    px_req = 1'b1;
    px_q.push_back(e);
    tick();
    px_req = 1'b0;
    tick();
  endtask

  // Memory model and request monitor.
  always @(negedge clk100) begin
    if (mem_bus.mem_req === 1'b1) begin
      if (waiting) begin
        vectors++;
        if (mem_bus.mem_addr !== held_addr) begin
          fails++;
          $display("FAIL addr_stable: got %0d, expected %0d", mem_bus.mem_addr, held_addr);
        end
      end
      if (ack_budget != 0 && wait_cnt >= ack_delay) begin
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_data = pix(mem_bus.mem_addr);
        wait_cnt = 0;
        waiting  = 1'b0;
        if (ack_budget > 0) ack_budget--;
        vectors++;
        if (exp_addr.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: got request at %0d, expected none", mem_bus.mem_addr);
        end else begin
          logic [18:0] e;
          e = exp_addr.pop_front();
          if (mem_bus.mem_addr !== e) begin
            fails++;
            $display("FAIL mem_addr: got %0d, expected %0d", mem_bus.mem_addr, e);
          end
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
        if (ack_budget != 0) wait_cnt++;
        waiting   = 1'b1;
        held_addr = mem_bus.mem_addr;
      end
    end else begin
      mem_bus.mem_ack = 1'b0;
      waiting  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Pixel read monitor: PxData is due one cycle after PxAddr.
  always @(negedge clk100) begin
    if (px_stage) begin
      vectors++;
      if (px_q.size() == 0) begin
        fails++;
        $display("FAIL pxdata: got %0d, expected no read pending", PxData);
      end else begin
        logic [7:0] e;
        e = px_q.pop_front();
        if (PxData !== e) begin
          fails++;
          $display("FAIL pxdata: got %0d, expected %0d", PxData, e);
        end
      end
    end
    px_stage = px_req;
  end

  initial begin
    rst = 1'b1;
    Line = 10'd0;
    PxAddr = 11'd0;
    underrun_clr = 1'b0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_data = 8'd0;
    tick();
    tick();
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_pxdata", 32'(PxData), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'(mem_bus.mem_req), 32'd0);

    // Line 9 -> fetch line 10, then Line 10 -> fetch line 11 into bank 1.
    ack_delay = 0;
    ack_budget = -1;
    push_fetch(6400, 640);
    Line = 10'd9;
    wait_empty("fetch_line10", 1000);
    chk("req_low_line10", 32'(mem_bus.mem_req), 32'd0);
    tick();
    push_fetch(7040, 640);
    Line = 10'd10;
    wait_empty("fetch_line11", 1000);
    chk("req_low_line11", 32'(mem_bus.mem_req), 32'd0);
    tick();
    chk("req_still_low", 32'(mem_bus.mem_req), 32'd0);
    chk("underrun_line11", 32'(underrun), 32'd0);
    rd(11'd1024, 8'h25);
    rd(11'd1029, 8'h20);
    rd(11'd1124, 8'h41);
    rd(11'd1663, 8'h5A);

    // Line 20: 100 acks then withheld; Line 21 aborts and restarts on line 22.
    ack_budget = 100;
    push_fetch(13440, 100);
    Line = 10'd20;
    wait_empty("partial_line21", 500);
    tick();
    tick();
    chk("stall_req", 32'(mem_bus.mem_req), 32'd1);
    chk("stall_addr", 32'(mem_bus.mem_addr), 32'd13540);
    Line = 10'd21;
    tick();
    chk("abort_req_low", 32'(mem_bus.mem_req), 32'd0);
    chk("abort_underrun", 32'(underrun), 32'd1);
    tick();
    chk("restart_req", 32'(mem_bus.mem_req), 32'd1);
    chk("restart_addr", 32'(mem_bus.mem_addr), 32'd14080);
`ifdef LINE_FETCH_STATS_EN
    chk("underrun_count1", 32'(underrun_count), 32'd1);
`endif
    // Line 22 completes with acks delayed 3 cycles per pixel.
    push_fetch(14080, 640);
    ack_delay = 3;
    ack_budget = -1;
    wait_empty("fetch_line22_slow", 3000);
    chk("req_low_line22", 32'(mem_bus.mem_req), 32'd0);
    ack_delay = 0;
    rd(11'd0, 8'hA5);
    rd(11'd1, 8'hA4);
    rd(11'd2, 8'hA7);
    rd(11'd639, 8'hDA);
    rd(11'd1123, 8'h46);
    rd(11'd1124, 8'h41);

    // Vblank lines request nothing; 523 -> 524 fetches line 0 into bank 0.
    Line = 10'd479;
    tick();
    tick();
    chk("no_req_479", 32'(mem_bus.mem_req), 32'd0);
    Line = 10'd480;
    tick();
    tick();
    chk("no_req_480", 32'(mem_bus.mem_req), 32'd0);
    Line = 10'd523;
    tick();
    tick();
    chk("no_req_523", 32'(mem_bus.mem_req), 32'd0);
    push_fetch(0, 640);
    Line = 10'd524;
    wait_empty("fetch_line0", 1000);
    chk("req_low_line0", 32'(mem_bus.mem_req), 32'd0);
    rd(11'd5, 8'hA0);
    rd(11'd639, 8'hDA);

    // underrun_clr alone clears; coinciding with an underrun event, set wins.
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);
    ack_budget = 0;
    Line = 10'd100;
    tick();
    tick();
    chk("line101_req", 32'(mem_bus.mem_req), 32'd1);
    chk("line101_addr", 32'(mem_bus.mem_addr), 32'd64640);
    Line = 10'd101;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("set_wins", 32'(underrun), 32'd1);
    chk("abort2_req_low", 32'(mem_bus.mem_req), 32'd0);
    tick();
    chk("line102_addr", 32'(mem_bus.mem_addr), 32'd65280);
`ifdef LINE_FETCH_STATS_EN
    chk("underrun_count2", 32'(underrun_count), 32'd2);
`endif

    // Reset mid-fetch drops the request immediately.
    rst = 1'b1;
    Line = 10'd0;
    #1;
    chk("async_rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("async_rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    chk("async_rst_underrun", 32'(underrun), 32'd0);
    tick();
    chk("rst_pxdata2", 32'(PxData), 32'd0);
`ifdef LINE_FETCH_STATS_EN
    chk("rst_count", 32'(underrun_count), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_req_after_rst", 32'(mem_bus.mem_req), 32'd0);
    end
    Line = 10'd1;
    tick();
    tick();
    chk("line2_req", 32'(mem_bus.mem_req), 32'd1);
    chk("line2_addr", 32'(mem_bus.mem_addr), 32'd1280);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
